// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register sequencer: register offsets,
// FSM state encoding, register-select codes and bit positions.
package uart_reg_pkg;

    localparam logic [11:0] OFS_TXDATA  = 12'h000;
    localparam logic [11:0] OFS_RXDATA  = 12'h004;
    localparam logic [11:0] OFS_CTRL    = 12'h008;
    localparam logic [11:0] OFS_BAUDDIV = 12'h00C;
    localparam logic [11:0] OFS_STATUS  = 12'h010;
    localparam logic [11:0] OFS_IRQEN   = 12'h014;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_WAIT,
        ST_RD,
        ST_RD_HOLD
    } uart_reg_state_e;

    typedef enum logic [2:0] {
        SEL_TXDATA,
        SEL_RXDATA,
        SEL_CTRL,
        SEL_BAUDDIV,
        SEL_STATUS,
        SEL_IRQEN,
        SEL_NONE
    } uart_reg_sel_e;

    localparam int CTRL_TX_EN    = 3;
    localparam int CTRL_RX_EN    = 2;
    localparam int CTRL_PAR_EN   = 1;
    localparam int CTRL_PAR_ODD  = 0;

    localparam int STAT_OVR      = 4;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 0;

    localparam int IRQ_OVR       = 3;
    localparam int IRQ_RX_FULL   = 2;
    localparam int IRQ_RX_AVAIL  = 1;
    localparam int IRQ_TX_EMPTY  = 0;

endpackage

// File: rtl/uart_irq_status.sv
// Sticky overrun flag and the registered, enable-masked interrupt output.
module uart_irq_status
    import uart_reg_pkg::*;
(
    input  logic       pclk,
    input  logic       prst,
    input  logic       rx_overrun,
    input  logic       ovr_clr,
    input  logic [3:0] irqen,
    input  logic       rx_full,
    input  logic       rx_empty,
    input  logic       tx_empty,
    output logic       ovr,
    output logic       irq
);

    logic       ovr_d, ovr_q;
    logic       irq_d, irq_q;
    logic [3:0] src;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        src = '0;
        src[IRQ_OVR]      = ovr_q;
        src[IRQ_RX_FULL]  = rx_full;
        src[IRQ_RX_AVAIL] = ~rx_empty;
        src[IRQ_TX_EMPTY] = tx_empty;

        // A new overrun in the same cycle as the STATUS-read clear must not be lost.
        ovr_d = ovr_q;
        if (rx_overrun) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        irq_d = |(irqen & src);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            ovr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            irq_q <= irq_d;
        end
    end

    assign ovr = ovr_q;
    assign irq = irq_q;

endmodule

// File: rtl/uart_reg_ctrl.sv
// Register bank and access sequencer behind the UART APB slave: decodes
// writes/reads, drives the FIFO push/pop ports and returns ack/error pulses.
module uart_reg_ctrl
    import uart_reg_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 32,
    parameter int          TX_WAIT_MAX = 16,
    parameter logic [15:0] BAUD_RST    = 16'd27
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              rack,
    output logic              wack,
    output logic              raddrerr,
    output logic              waddrerr,
    input  logic              tx_full,
    input  logic              tx_empty,
    input  logic              rx_full,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    input  logic              rx_overrun,
    output logic              tx_push,
    output logic [7:0]        tx_data,
    output logic              rx_pop,
    output logic [3:0]        ctrl,
    output logic [15:0]       baud_div,
    output logic              irq
);

    localparam int CNT_W = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

    uart_reg_state_e   state_d, state_q;
    uart_reg_sel_e     sel;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [15:0]       wdata_d, wdata_q;
    logic [CNT_W-1:0]  wait_cnt_d, wait_cnt_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rack_d, rack_q, raddrerr_d, raddrerr_q;
    logic              wack_d, wack_q, waddrerr_d, waddrerr_q;
    logic              tx_push_d, tx_push_q, rx_pop_d, rx_pop_q;
    logic [7:0]        tx_data_d, tx_data_q;
    logic [3:0]        ctrl_d, ctrl_q, irqen_d, irqen_q;
    logic [15:0]       baud_d, baud_q;
    logic              ovr_clr_d, ovr_clr_q;
    logic              ovr;
    logic [4:0]        status;
    logic              unused_wdata;

    // Only the low 16 bits of any register are implemented.
    assign unused_wdata = ^wdata[DATA_W-1:16];

    function automatic uart_reg_sel_e reg_decode(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(OFS_TXDATA))  return SEL_TXDATA;
        if (a == ADDR_W'(OFS_RXDATA))  return SEL_RXDATA;
        if (a == ADDR_W'(OFS_CTRL))    return SEL_CTRL;
        if (a == ADDR_W'(OFS_BAUDDIV)) return SEL_BAUDDIV;
        if (a == ADDR_W'(OFS_STATUS))  return SEL_STATUS;
        if (a == ADDR_W'(OFS_IRQEN))   return SEL_IRQEN;
        return SEL_NONE;
    endfunction

    always_comb begin
        status = '0;
        status[STAT_OVR]      = ovr;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
    end

    always_comb begin
        sel        = reg_decode(addr_q);
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = '0;
        rack_d     = 1'b0;
        raddrerr_d = 1'b0;
        wack_d     = 1'b0;
        waddrerr_d = 1'b0;
        tx_push_d  = 1'b0;
        tx_data_d  = '0;
        rx_pop_d   = 1'b0;
        ovr_clr_d  = 1'b0;
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        irqen_d    = irqen_q;

        case (state_q)
            ST_IDLE: begin
                // Write wins a tie; the held rd_en is served on a later pass.
                if (wr_en) begin
                    addr_d  = waddr;
                    wdata_d = wdata[15:0];
                    state_d = ST_WR;
                end else if (rd_en) begin
                    addr_d  = raddr;
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
                wack_d  = 1'b1;
                case (sel)
                    SEL_TXDATA: begin
                        if (tx_full) begin
                            wack_d     = 1'b0;
                            wait_cnt_d = '0;
                            state_d    = ST_WR_WAIT;
                        end else begin
                            tx_push_d = 1'b1;
                            tx_data_d = wdata_q[7:0];
                        end
                    end
                    SEL_CTRL:    ctrl_d  = wdata_q[3:0];
                    SEL_BAUDDIV: baud_d  = wdata_q;
                    SEL_IRQEN:   irqen_d = wdata_q[3:0];
                    default:     waddrerr_d = 1'b1;
                endcase
            end
            ST_WR_WAIT: begin
                if (!tx_full) begin
                    tx_push_d = 1'b1;
                    tx_data_d = wdata_q[7:0];
                    wack_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wait_cnt_q == CNT_W'(TX_WAIT_MAX - 1)) begin
                    wack_d     = 1'b1;
                    waddrerr_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_RD: begin
                rack_d  = 1'b1;
                state_d = ST_RD_HOLD;
                case (sel)
                    SEL_RXDATA: begin
                        rdata_d  = rx_empty ? '0 : DATA_W'(rx_data);
                        rx_pop_d = ~rx_empty;
                    end
                    SEL_CTRL:    rdata_d = DATA_W'(ctrl_q);
                    SEL_BAUDDIV: rdata_d = DATA_W'(baud_q);
                    SEL_STATUS: begin
                        rdata_d   = DATA_W'(status);
                        ovr_clr_d = 1'b1;
                    end
                    SEL_IRQEN:   rdata_d = DATA_W'(irqen_q);
                    default:     raddrerr_d = 1'b1;
                endcase
            end
            ST_RD_HOLD: begin
                // rd_en is a level; one access phase must yield exactly one rack/pop.
                if (!rd_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            rack_q     <= 1'b0;
            raddrerr_q <= 1'b0;
            wack_q     <= 1'b0;
            waddrerr_q <= 1'b0;
            tx_push_q  <= 1'b0;
            tx_data_q  <= '0;
            rx_pop_q   <= 1'b0;
            ovr_clr_q  <= 1'b0;
            ctrl_q     <= '0;
            baud_q     <= BAUD_RST;
            irqen_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            rack_q     <= rack_d;
            raddrerr_q <= raddrerr_d;
            wack_q     <= wack_d;
            waddrerr_q <= waddrerr_d;
            tx_push_q  <= tx_push_d;
            tx_data_q  <= tx_data_d;
            rx_pop_q   <= rx_pop_d;
            ovr_clr_q  <= ovr_clr_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            irqen_q    <= irqen_d;
        end
    end

    uart_irq_status u_irq_status (
        .pclk       (pclk),
        .prst       (prst),
        .rx_overrun (rx_overrun),
        .ovr_clr    (ovr_clr_q),
        .irqen      (irqen_q),
        .rx_full    (rx_full),
        .rx_empty   (rx_empty),
        .tx_empty   (tx_empty),
        .ovr        (ovr),
        .irq        (irq)
    );

    assign rdata    = rdata_q;
    assign rack     = rack_q;
    assign raddrerr = raddrerr_q;
    assign wack     = wack_q;
    assign waddrerr = waddrerr_q;
    assign tx_push  = tx_push_q;
    assign tx_data  = tx_data_q;
    assign rx_pop   = rx_pop_q;
    assign ctrl     = ctrl_q;
    assign baud_div = baud_q;

endmodule
